pipeline_stall_flush_controller: RTL and testbench
==================================================

Name: pipeline_stall_flush_controller

Overview:
Sequential pipeline-control stage that sits directly downstream of the hazard detection unit. It combines three inputs into the per-latch enable, flush and nop-insert controls for the 5-stage pipeline:
- the load-use stall request from the hazard unit;
- branch/jump resolution from the X stage;
- a multi-cycle mult/div handshake, run by an internal FSM.

It also issues mult/div start pulses, captures mult/div exceptions for the XM error latch, and keeps stall/flush performance counters.

Parameters:
MULTDIV_TIMEOUT, 40, BUSY cycles before the watchdog forces DONE with the exception flag set.
COUNT_WIDTH, 32, width of the saturating performance counters.

Ports:
clock  input  1  pipeline clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
DX_Latch_Instr  input  32  instruction in the DX latch (opcode [31:27], ALU op [6:2])
DX_stalling_mux_select  input  1  load-use stall request from the hazard unit
Branch_Taken  input  1  X-stage control transfer taken (bne/blt taken, j, jal, jr, bex taken)
Multdiv_Result_Ready  input  1  mult/div unit result valid
Multdiv_Exception  input  1  mult/div overflow / divide-by-zero; sampled only with Result_Ready
PC_Enable  output  1  PC register write enable
FD_Latch_Enable  output  1  FD latch write enable
DX_Latch_Enable  output  1  DX latch write enable
FD_Flush  output  1  load nop into FD
DX_Insert_Nop  output  1  load nop into DX
XM_Insert_Nop  output  1  load nop into XM
ctrl_MULT  output  1  one-cycle mult start pulse
ctrl_DIV  output  1  one-cycle div start pulse
Multdiv_Result_Select  output  1  route the mult/div result into XM instead of the ALU result
Multdiv_ErrorFlag  output  1  error flag into the XM error latch, valid with Result_Select
Stall_Cycle_Count  output  COUNT_WIDTH  saturating count of cycles with PC_Enable=0
Flush_Count  output  COUNT_WIDTH  saturating count of taken branches

Behaviour:
- The instruction in DX is a mul/div when opcode==0 and ALU op==00110 (mul) or 00111 (div). Any other instruction is plain.
- FSM states and transitions:
  - IDLE -> BUSY when DX holds a mul/div and Branch_Taken=0. In that cycle, pulse ctrl_MULT or ctrl_DIV for exactly one cycle.
  - BUSY -> DONE when Multdiv_Result_Ready=1, or when the BUSY cycle counter reaches MULTDIV_TIMEOUT-1.
  - DONE -> IDLE unconditionally after one cycle.
- Cycle counter: cleared on entry to BUSY; increments each BUSY cycle; does not wrap.
- IDLE with a mul/div detected (start cycle) and BUSY:
  - PC_Enable, FD_Latch_Enable and DX_Latch_Enable are 0.
  - XM_Insert_Nop=1, so XM/MW drain.
  - Branch_Taken and DX_stalling_mux_select are ignored.
- DONE:
  - All enables are 1 and XM_Insert_Nop=0.
  - Multdiv_Result_Select=1.
  - Multdiv_ErrorFlag = registered Multdiv_Exception, or 1 on timeout.
  - The DX instruction advances at the end of DONE, so the same mul/div is never restarted.
  - A back-to-back mul/div starts in the following IDLE cycle.
- IDLE, no mul/div start, priority Branch_Taken > load-use:
  - Branch_Taken: FD_Flush=1, DX_Insert_Nop=1, PC/FD/DX enables=1 (PC loads target), Flush_Count+1.
  - DX_stalling_mux_select: PC_Enable=0, FD_Latch_Enable=0, DX_Latch_Enable=1, DX_Insert_Nop=1 (one bubble).
  - Otherwise: all enables=1, all flush/nop=0.
- Multdiv_Result_Ready outside BUSY is ignored. Multdiv_Exception is registered only when Ready is high in BUSY.
- Counters saturate at all-ones and never wrap.
- Reset:
  - Dominates every input.
  - Next state IDLE; cycle counter, exception register and both perf counters cleared.
  - Reset mid-BUSY aborts the operation with no further start pulse.
  - Output values with reset asserted: enables=1; FD_Flush, DX_Insert_Nop, XM_Insert_Nop, ctrl_MULT, ctrl_DIV, Multdiv_Result_Select and Multdiv_ErrorFlag all 0.
- Output timing: outputs are combinational from state plus the current inputs, with zero added latency. Start pulses are asserted in the cycle the instruction is detected.

Decomposition:
- Shared package holds:
  - opcode constants: ALU=0, LW=8, SW=7, BNE=2, BLT=6, JR=4, JAL=3, BEX=22, SETX=21;
  - ALU op constants MUL=00110, DIV=00111;
  - the FSM state encoding IDLE/BUSY/DONE.
- One sub-module, multdiv_sequencer: FSM, timeout counter, start pulses and exception capture.
- The top level does the priority muxing and holds the perf counters.

Test Plan:
1. mul r3,r1,r2 enters DX; Ready rises after 32 BUSY cycles, Exception=0 -> ctrl_MULT high one cycle; PC/FD/DX enables 0 for 33 cycles (start + 32 BUSY); DONE: Result_Select=1, ErrorFlag=0; Stall_Cycle_Count=33.
2. lw r4 in DX with DX_stalling_mux_select=1 for one cycle -> PC/FD enables 0 and DX_Insert_Nop=1 for exactly 1 cycle; Stall_Cycle_Count=1.
3. Branch_Taken=1 and DX_stalling_mux_select=1 in the same cycle -> FD_Flush=1, DX_Insert_Nop=1, PC_Enable=1; Flush_Count=1; Stall_Cycle_Count unchanged.
4. div with Ready and Exception arriving together after 5 cycles -> ctrl_DIV pulse; DONE: ErrorFlag=1; Ready pulses in IDLE are ignored.
5. div with Ready never asserted -> DONE after 40 BUSY cycles, ErrorFlag=1, then IDLE.
6. reset asserted in the 3rd BUSY cycle -> next cycle IDLE, enables 1, counters 0; mul still in DX after reset -> fresh ctrl_MULT pulse.

Source files
------------

// File: rtl/pipeline_stall_flush_controller_pkg.sv
// Shared constants and types for the pipeline stall/flush controller:
// instruction field encodings and the mult/div sequencer state encoding.
package pipeline_stall_flush_controller_pkg;

  // Opcode field, instruction bits [31:27]
  localparam logic [4:0] OP_ALU  = 5'd0;
  localparam logic [4:0] OP_LW   = 5'd8;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_BEX  = 5'd22;
  localparam logic [4:0] OP_SETX = 5'd21;

  // ALU op field, instruction bits [6:2]
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // True when the instruction is an R-type mul or div.
  function automatic logic is_multdiv(input logic [31:0] instr);
    return (instr[31:27] == OP_ALU) &&
           ((instr[6:2] == ALUOP_MUL) || (instr[6:2] == ALUOP_DIV));
  endfunction

endpackage

// File: rtl/pipeline_stall_flush_controller_multdiv_sequencer.sv
// Mult/div handshake sequencer: IDLE/BUSY/DONE FSM, watchdog counter,
// one-cycle start pulses and exception capture for the XM error latch.
module multdiv_sequencer
  import pipeline_stall_flush_controller_pkg::*;
#(
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic multdiv_i,       // DX holds a mul or div
  input  logic is_div_i,        // DX ALU op selects div
  input  logic branch_taken_i,
  input  logic ready_i,
  input  logic exception_i,
  output logic stall_o,         // start cycle or BUSY: freeze front end
  output logic done_o,
  output logic start_mult_o,
  output logic start_div_o,
  output logic error_flag_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               start, busy, done;

  // Next-state, watchdog and exception-capture logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    start   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (multdiv_i && !branch_taken_i) begin
          start   = 1'b1;
          state_d = MD_BUSY;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      MD_BUSY: begin
        busy = 1'b1;
        if (ready_i) begin
          state_d = MD_DONE;
          err_d   = exception_i;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = MD_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MD_DONE: begin
        done    = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // State register with synchronous reset; reset aborts any operation.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Reset masks every output so the pipeline sees plain enables during reset.
  assign stall_o      = (start || busy) && !reset;
  assign done_o       = done && !reset;
  assign start_mult_o = start && !is_div_i && !reset;
  assign start_div_o  = start && is_div_i && !reset;
  assign error_flag_o = done_o && err_q;

endmodule

// File: rtl/pipeline_stall_flush_controller.sv
// Pipeline stall/flush controller: merges load-use stalls, X-stage branch
// resolution and the mult/div handshake into per-latch enable/flush controls,
// and keeps saturating stall and flush performance counters.
module pipeline_stall_flush_controller
  import pipeline_stall_flush_controller_pkg::*;
#(
  parameter int MULTDIV_TIMEOUT = 40,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            DX_Latch_Instr,
  input  logic                   DX_stalling_mux_select,
  input  logic                   Branch_Taken,
  input  logic                   Multdiv_Result_Ready,
  input  logic                   Multdiv_Exception,
  output logic                   PC_Enable,
  output logic                   FD_Latch_Enable,
  output logic                   DX_Latch_Enable,
  output logic                   FD_Flush,
  output logic                   DX_Insert_Nop,
  output logic                   XM_Insert_Nop,
  output logic                   ctrl_MULT,
  output logic                   ctrl_DIV,
  output logic                   Multdiv_Result_Select,
  output logic                   Multdiv_ErrorFlag,
  output logic [COUNT_WIDTH-1:0] Stall_Cycle_Count,
  output logic [COUNT_WIDTH-1:0] Flush_Count
);

  logic md_stall, md_done, md_err;
  logic flush_evt;
  logic [COUNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [COUNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // Register/shamt fields are irrelevant to pipeline control.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{DX_Latch_Instr[26:7], DX_Latch_Instr[1:0]};

  multdiv_sequencer #(
    .TIMEOUT(MULTDIV_TIMEOUT)
  ) u_seq (
    .clock          (clock),
    .reset          (reset),
    .multdiv_i      (is_multdiv(DX_Latch_Instr)),
    .is_div_i       (DX_Latch_Instr[6:2] == ALUOP_DIV),
    .branch_taken_i (Branch_Taken),
    .ready_i        (Multdiv_Result_Ready),
    .exception_i    (Multdiv_Exception),
    .stall_o        (md_stall),
    .done_o         (md_done),
    .start_mult_o   (ctrl_MULT),
    .start_div_o    (ctrl_DIV),
    .error_flag_o   (md_err)
  );

  // Priority mux: reset > mult/div done > mult/div stall > branch > load-use.
  always_comb begin
    PC_Enable             = 1'b1;
    FD_Latch_Enable       = 1'b1;
    DX_Latch_Enable       = 1'b1;
    FD_Flush              = 1'b0;
    DX_Insert_Nop         = 1'b0;
    XM_Insert_Nop         = 1'b0;
    Multdiv_Result_Select = 1'b0;
    Multdiv_ErrorFlag     = 1'b0;
    flush_evt             = 1'b0;
    if (reset) begin
      // defaults already describe the reset-time outputs
    end else if (md_done) begin
      Multdiv_Result_Select = 1'b1;
      Multdiv_ErrorFlag     = md_err;
    end else if (md_stall) begin
      PC_Enable       = 1'b0;
      FD_Latch_Enable = 1'b0;
      DX_Latch_Enable = 1'b0;
      XM_Insert_Nop   = 1'b1;
    end else if (Branch_Taken) begin
      FD_Flush      = 1'b1;
      DX_Insert_Nop = 1'b1;
      flush_evt     = 1'b1;
    end else if (DX_stalling_mux_select) begin
      PC_Enable       = 1'b0;
      FD_Latch_Enable = 1'b0;
      DX_Insert_Nop   = 1'b1;
    end
  end

  // Saturating performance counter increments.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PC_Enable && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_evt && (flush_cnt_q != '1))  flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Performance counter registers, cleared by synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Stall_Cycle_Count = stall_cnt_q;
  assign Flush_Count       = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_flush_controller.sv
// Self-checking bench for pipeline_stall_flush_controller: directed scenarios
// followed by random stimulus, all compared against a behavioural model.
module tb_pipeline_stall_flush_controller;

  localparam int TIMEOUT = 40;
  localparam int CW      = 8;
  localparam int SAT     = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   instr;
  logic          ld_stall, br, ready, exc;
  logic          pc_en, fd_en, dx_en, fd_flush, dx_nop, xm_nop;
  logic          c_mult, c_div, rsel, eflag;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clock = ~clock;

  pipeline_stall_flush_controller #(
    .MULTDIV_TIMEOUT(TIMEOUT),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .DX_Latch_Instr        (instr),
    .DX_stalling_mux_select(ld_stall),
    .Branch_Taken          (br),
    .Multdiv_Result_Ready  (ready),
    .Multdiv_Exception     (exc),
    .PC_Enable             (pc_en),
    .FD_Latch_Enable       (fd_en),
    .DX_Latch_Enable       (dx_en),
    .FD_Flush              (fd_flush),
    .DX_Insert_Nop         (dx_nop),
    .XM_Insert_Nop         (xm_nop),
    .ctrl_MULT             (c_mult),
    .ctrl_DIV              (c_div),
    .Multdiv_Result_Select (rsel),
    .Multdiv_ErrorFlag     (eflag),
    .Stall_Cycle_Count     (stall_cnt),
    .Flush_Count           (flush_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Output vector order: {PC,FD,DX,FD_Flush,DX_Nop,XM_Nop,MULT,DIV,RSel,ErrFlag}
  localparam logic [9:0] O_NORMAL   = 10'b1110000000;
  localparam logic [9:0] O_LOADUSE  = 10'b0010100000;
  localparam logic [9:0] O_BRANCH   = 10'b1111100000;
  localparam logic [9:0] O_START_M  = 10'b0000011000;
  localparam logic [9:0] O_START_D  = 10'b0000010100;
  localparam logic [9:0] O_BUSY     = 10'b0000010000;
  localparam logic [9:0] O_DONE_OK  = 10'b1110000010;
  localparam logic [9:0] O_DONE_ERR = 10'b1110000011;

  // Behavioural model: an operation is "in flight" for some number of
  // elapsed BUSY cycles, then spends exactly one cycle delivering its result.
  bit         m_active, m_done, m_err;
  int         m_elapsed, m_stall, m_flush;
  logic [9:0] exp_cur, last_out;
  int         n_mult, n_div, n_frozen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] aluop, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
    return {5'd0, rd, rs, rt, 5'd0, aluop, 2'b00};
  endfunction

  function automatic logic [9:0] model_out();
    logic md, d;
    md = (instr[31:27] == 5'd0) && (instr[6:2] == 5'b00110 || instr[6:2] == 5'b00111);
    d  = (instr[6:2] == 5'b00111);
    if (reset)              return O_NORMAL;
    if (m_done)             return {8'b11100000, 1'b1, m_err};
    if (m_active)           return O_BUSY;
    if (md && !br)          return {6'b000001, ~d, d, 2'b00};
    if (br)                 return O_BRANCH;
    if (ld_stall)           return O_LOADUSE;
    return O_NORMAL;
  endfunction

  // One clock cycle: check outputs mid-cycle, advance the model across the
  // edge, then check the counters. Inputs are driven around the negedge.
  task automatic tick();
    logic [9:0] obs;
    #1;
    exp_cur = model_out();
    obs = {pc_en, fd_en, dx_en, fd_flush, dx_nop, xm_nop, c_mult, c_div, rsel, eflag};
    check("outputs", {22'd0, obs}, {22'd0, exp_cur});
    last_out = obs;
    n_mult   += int'(c_mult);
    n_div    += int'(c_div);
    n_frozen += int'(!pc_en);
    @(posedge clock);
    #1;
    if (reset) begin
      m_active = 0; m_done = 0; m_err = 0; m_elapsed = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!exp_cur[9] && m_stall < SAT) m_stall++;
      if (exp_cur[6] && m_flush < SAT)  m_flush++;
      if (m_done) m_done = 0;
      else if (m_active) begin
        m_elapsed++;
        if (ready) begin
          m_active = 0; m_done = 1; m_err = exc;
        end else if (m_elapsed == TIMEOUT) begin
          m_active = 0; m_done = 1; m_err = 1;
        end
      end else if (exp_cur[3] || exp_cur[2]) begin
        m_active = 1; m_elapsed = 0;
      end
    end
    check("stall_count", {24'd0, stall_cnt}, m_stall);
    check("flush_count", {24'd0, flush_cnt}, m_flush);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    reset = 0; instr = mk_r(5'b00000, 5'd5, 5'd6, 5'd7); // add
    ld_stall = 0; br = 0; ready = 0; exc = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    n_mult = 0; n_div = 0; n_frozen = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    n_mult = 0; n_div = 0; n_frozen = 0;
    @(negedge clock);

    // Reset: outputs forced to plain enables, counters cleared
    do_reset();
    check("reset_outputs", {22'd0, last_out}, {22'd0, O_NORMAL});
    check("reset_stall_cnt", {24'd0, stall_cnt}, 0);

    // 1: mul, Ready in the 32nd BUSY cycle
    instr = mk_r(5'b00110, 5'd3, 5'd1, 5'd2);
    tick();
    check("t1_start", {22'd0, last_out}, {22'd0, O_START_M});
    for (int i = 0; i < 31; i++) tick();
    ready = 1;
    tick();
    ready = 0;
    tick();
    check("t1_done", {22'd0, last_out}, {22'd0, O_DONE_OK});
    instr = mk_r(5'b00000, 5'd5, 5'd6, 5'd7);
    tick();
    check("t1_mult_pulses", n_mult, 1);
    check("t1_frozen", n_frozen, 33);
    check("t1_stall_cnt", {24'd0, stall_cnt}, 33);

    // 2: lw with one load-use stall cycle
    do_reset();
    instr = {5'd8, 5'd4, 5'd1, 17'd0};
    ld_stall = 1;
    tick();
    check("t2_loaduse", {22'd0, last_out}, {22'd0, O_LOADUSE});
    ld_stall = 0;
    tick();
    check("t2_after", {22'd0, last_out}, {22'd0, O_NORMAL});
    check("t2_stall_cnt", {24'd0, stall_cnt}, 1);

    // 3: branch beats load-use
    br = 1; ld_stall = 1;
    tick();
    check("t3_branch", {22'd0, last_out}, {22'd0, O_BRANCH});
    br = 0; ld_stall = 0;
    check("t3_flush_cnt", {24'd0, flush_cnt}, 1);
    check("t3_stall_cnt", {24'd0, stall_cnt}, 1);

    // 4: div with Ready+Exception in the 5th BUSY cycle; Ready in IDLE ignored
    do_reset();
    instr = mk_r(5'b00111, 5'd8, 5'd9, 5'd10);
    ready = 1; exc = 1;            // Ready during the start cycle is ignored
    tick();
    check("t4_start", {22'd0, last_out}, {22'd0, O_START_D});
    ready = 0; exc = 0;
    for (int i = 0; i < 4; i++) tick();
    ready = 1; exc = 1;
    tick();
    ready = 0; exc = 0;
    tick();
    check("t4_done_err", {22'd0, last_out}, {22'd0, O_DONE_ERR});
    instr = mk_r(5'b00000, 5'd5, 5'd6, 5'd7);
    ready = 1; exc = 1;
    tick();
    tick();
    check("t4_idle_ready", {22'd0, last_out}, {22'd0, O_NORMAL});
    ready = 0; exc = 0;
    check("t4_div_pulses", n_div, 1);

    // 5: div with no Ready -> watchdog after 40 BUSY cycles
    do_reset();
    instr = mk_r(5'b00111, 5'd8, 5'd9, 5'd10);
    for (int i = 0; i < TIMEOUT + 1; i++) tick();
    check("t5_last_busy", {22'd0, last_out}, {22'd0, O_BUSY});
    tick();
    check("t5_done_timeout", {22'd0, last_out}, {22'd0, O_DONE_ERR});
    instr = mk_r(5'b00000, 5'd5, 5'd6, 5'd7);
    tick();
    check("t5_back_idle", {22'd0, last_out}, {22'd0, O_NORMAL});
    check("t5_frozen", n_frozen, TIMEOUT + 1);

    // 6: reset in the 3rd BUSY cycle, mul remains in DX
    do_reset();
    instr = mk_r(5'b00110, 5'd3, 5'd1, 5'd2);
    tick(); tick(); tick();
    reset = 1;
    tick();
    check("t6_reset_out", {22'd0, last_out}, {22'd0, O_NORMAL});
    check("t6_cnt_cleared", {24'd0, stall_cnt}, 0);
    reset = 0;
    tick();
    check("t6_restart", {22'd0, last_out}, {22'd0, O_START_M});
    check("t6_mult_pulses", n_mult, 2);

    // Random phase
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      int r;
      reset    = ($urandom_range(0, 99) < 2);
      br       = ($urandom_range(0, 4) == 0);
      ld_stall = ($urandom_range(0, 3) == 0);
      ready    = ($urandom_range(0, 7) == 0);
      exc      = $urandom_range(0, 1) == 1;
      if (m_done) begin br = 0; ld_stall = 0; end
      if (!m_active && !m_done) begin
        r = $urandom_range(0, 9);
        instr = $urandom();
        if (r < 3)      instr = mk_r(5'b00110, 5'(r), 5'd1, 5'd2);
        else if (r < 5) instr = mk_r(5'b00111, 5'(r), 5'd1, 5'd2);
        else if (r < 8) instr[31:27] = 5'($urandom_range(1, 31));
        else            instr[31:27] = 5'd0;
      end
      tick();
    end

    // Saturation of both counters
    idle_inputs();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      instr = mk_r(5'b00111, 5'd8, 5'd9, 5'd10);
      for (int i = 0; i < TIMEOUT + 2; i++) tick();
      instr = mk_r(5'b00000, 5'd5, 5'd6, 5'd7);
      tick();
    end
    check("sat_stall_cnt", {24'd0, stall_cnt}, SAT);
    br = 1;
    for (int i = 0; i < SAT + 5; i++) tick();
    br = 0;
    check("sat_flush_cnt", {24'd0, flush_cnt}, SAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
